// File: rtl/reflet_debug_bridge_if.sv
// Bundle of the byte-stream and system-bus signals around the debug bridge.
// The master modport is the bridge side and the slave modport is the
// environment side: the UART, the response sink, the arbiter and the bus.
interface reflet_debug_bridge_if #(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16
);
    // Command byte stream into the bridge
    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_ready;
    // Response byte stream out of the bridge
    logic [7:0]                out_data;
    logic                      out_valid;
    logic                      out_ready;
    // System bus initiator side
    logic                      bus_request;
    logic                      bus_grant;
    logic                      enable;
    logic [base_addr_size-1:0] addr;
    logic [wordsize-1:0]       data_out;
    logic [wordsize-1:0]       data_in;
    logic                      write_en;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output bus_request,
        input  bus_grant,
        output enable, addr, data_out, write_en,
        input  data_in
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  bus_request,
        output bus_grant,
        input  enable, addr, data_out, write_en,
        output data_in
    );
endinterface

// File: rtl/reflet_debug_bridge.sv
// Byte-stream to Reflet system bus initiator. It decodes 'W'/'R' commands
// (little-endian address and data fields), requests the bus, performs a
// single one-cycle access and streams back an ACK, the read data or a NAK.
module reflet_debug_bridge #(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16,
    parameter int timeout_cycles = 1000000
) (
    input logic                   clk,
    input logic                   reset,
    reflet_debug_bridge_if.master bif
);

    localparam int AB    = (base_addr_size + 7) / 8;
    localparam int WB    = wordsize / 8;
    localparam int MAXB  = (AB > WB) ? AB : WB;
    localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) + 1 : 1;
    localparam int TMO_W = $clog2(timeout_cycles);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_ACCESS,
        S_RESP,
        S_NAK
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic                      r_is_write;
    logic [CNT_W-1:0]          r_cnt;
    logic [TMO_W-1:0]          r_tmo;
    logic [base_addr_size-1:0] r_addr_sh;
    logic [wordsize-1:0]       r_data_sh;
    logic [base_addr_size-1:0] r_addr_out;
    logic [wordsize-1:0]       r_data_out;
    logic [wordsize-1:0]       r_rdata;

    logic [base_addr_size-1:0] w_addr_sh_next;
    logic [wordsize-1:0]       w_data_sh_next;

    logic                      w_in_ready;
    logic                      w_out_valid;
    logic [7:0]                w_out_data;
    logic                      w_bus_request;
    logic                      w_enable;
    logic                      w_write_en;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_tmo_hit;
    logic                      w_addr_last;
    logic                      w_data_last;
    logic                      w_resp_last;

    assign w_in_fire   = bif.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bif.out_ready;
    assign w_tmo_hit   = (r_tmo == TMO_W'(timeout_cycles - 1));
    assign w_addr_last = (r_cnt == CNT_W'(AB - 1));
    assign w_data_last = (r_cnt == CNT_W'(WB - 1));
    // A write answers with a single ACK byte; a read streams WB data bytes
    assign w_resp_last = r_is_write | w_data_last;

    genvar gi;

    // Address byte lanes: byte n of the command lands in lane n. The last
    // lane may be narrower than a byte, which drops the unused upper bits.
    for (gi = 0; gi < AB; gi++) begin : g_addr_lane
        localparam int LW = ((base_addr_size - gi * 8) >= 8) ? 8 : (base_addr_size - gi * 8);
        assign w_addr_sh_next[gi*8 +: LW] =
            (w_in_fire && r_state == S_ADDR && r_cnt == CNT_W'(gi)) ?
            bif.in_data[LW-1:0] : r_addr_sh[gi*8 +: LW];
    end

    // Write-data byte lanes, same little-endian placement as the address
    for (gi = 0; gi < WB; gi++) begin : g_data_lane
        assign w_data_sh_next[gi*8 +: 8] =
            (w_in_fire && r_state == S_DATA && r_cnt == CNT_W'(gi)) ?
            bif.in_data : r_data_sh[gi*8 +: 8];
    end

    // State register; reset aborts whatever command or response is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (bif.in_data == CMD_WRITE || bif.in_data == CMD_READ) begin
                        w_state_next = S_ADDR;
                    end else begin
                        w_state_next = S_NAK;
                    end
                end
            end
            S_ADDR: begin
                if (w_in_fire) begin
                    if (w_addr_last) begin
                        w_state_next = r_is_write ? S_DATA : S_REQ;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_in_fire) begin
                    if (w_data_last) begin
                        w_state_next = S_REQ;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (bif.bus_grant) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (w_out_fire && w_resp_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_NAK: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state only
    always_comb begin
        w_in_ready    = 1'b0;
        w_out_valid   = 1'b0;
        w_out_data    = 8'h00;
        w_bus_request = 1'b0;
        w_enable      = 1'b0;
        w_write_en    = 1'b0;
        case (r_state)
            S_IDLE, S_ADDR, S_DATA: begin
                w_in_ready = 1'b1;
            end
            S_REQ: begin
                w_bus_request = 1'b1;
            end
            S_ACCESS: begin
                w_bus_request = 1'b1;
                w_enable      = 1'b1;
                w_write_en    = r_is_write;
            end
            S_RESP: begin
                w_out_valid = 1'b1;
                w_out_data  = r_is_write ? RESP_ACK : r_rdata[7:0];
            end
            S_NAK: begin
                w_out_valid = 1'b1;
                w_out_data  = RESP_NAK;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: byte/timeout counters, field assembly, bus registers, read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_addr_sh  <= '0;
            r_data_sh  <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_rdata    <= '0;
        end else begin
            // Byte counter restarts at every state change so each phase
            // counts its own bytes from lane 0
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_in_fire || w_out_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Idle-cycle counter only runs while a command is half received
            if ((r_state == S_ADDR || r_state == S_DATA) &&
                (w_state_next == r_state) && !w_in_fire) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end

            if (r_state == S_IDLE && w_in_fire) begin
                r_is_write <= (bif.in_data == CMD_WRITE);
            end

            r_addr_sh <= w_addr_sh_next;
            r_data_sh <= w_data_sh_next;

            // Bus address/data are loaded once on entry to ACCESS and then
            // held, so they never ripple while the next command streams in
            if (r_state == S_REQ && bif.bus_grant) begin
                r_addr_out <= r_addr_sh;
                if (r_is_write) begin
                    r_data_out <= r_data_sh;
                end
            end

            // Read data is captured on the closing edge of ACCESS and then
            // shifted down one byte per accepted response byte
            if (r_state == S_ACCESS && !r_is_write) begin
                r_rdata <= bif.data_in;
            end else if (r_state == S_RESP && w_out_fire) begin
                r_rdata <= r_rdata >> 8;
            end
        end
    end

    assign bif.in_ready    = w_in_ready;
    assign bif.out_valid   = w_out_valid;
    assign bif.out_data    = w_out_data;
    assign bif.bus_request = w_bus_request;
    assign bif.enable      = w_enable;
    assign bif.write_en    = w_write_en;
    assign bif.addr        = r_addr_out;
    assign bif.data_out    = r_data_out;

endmodule

// File: tb/tb_reflet_debug_bridge.sv
// Self-checking bench for reflet_debug_bridge (16-bit bus, timeout of 8).
// Expected bus accesses and response bytes are queued when a command is sent
// and popped by a monitor when the bridge produces them.
module tb_reflet_debug_bridge;

    localparam int WS  = 16;
    localparam int AW  = 16;
    localparam int TMO = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [WS-1:0] wdata;
    } acc_t;

    logic clk;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    acc_t       sb_acc[$];
    logic [7:0] sb_bytes[$];

    reflet_debug_bridge_if #(.wordsize(WS), .base_addr_size(AW)) bif ();

    reflet_debug_bridge #(
        .wordsize      (WS),
        .base_addr_size(AW),
        .timeout_cycles(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bif  (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: samples mid low phase, well clear of the rising edge
    always begin : mon
        acc_t       e;
        logic [7:0] eb;
        @(negedge clk);
        #2;
        if (reset) begin
            if (bif.enable) begin
                compared++;
                if (sb_acc.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_access: addr=%h we=%b data=%h, required no access",
                             bif.addr, bif.write_en, bif.data_out);
                end else begin
                    e = sb_acc.pop_front();
                    if (bif.addr !== e.addr || bif.write_en !== e.we ||
                        (e.we && bif.data_out !== e.wdata)) begin
                        mismatched++;
                        $display("FAIL bus_access: addr=%h we=%b data=%h, required addr=%h we=%b data=%h",
                                 bif.addr, bif.write_en, bif.data_out, e.addr, e.we, e.wdata);
                    end else begin
                        $display("[%0t] access addr=%h we=%b data=%h ok", $time,
                                 bif.addr, bif.write_en, e.we ? bif.data_out : bif.data_in);
                    end
                end
            end
            if (bif.out_valid && bif.out_ready) begin
                compared++;
                if (sb_bytes.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_resp_byte: got %h, required none", bif.out_data);
                end else begin
                    eb = sb_bytes.pop_front();
                    if (bif.out_data !== eb) begin
                        mismatched++;
                        $display("FAIL resp_byte: got %h, required %h", bif.out_data, eb);
                    end else begin
                        $display("[%0t] response byte %h ok", $time, bif.out_data);
                    end
                end
            end
        end
    end

    task automatic push_acc(input logic [AW-1:0] a, input logic we, input logic [WS-1:0] d);
        acc_t e;
        e.addr  = a;
        e.we    = we;
        e.wdata = d;
        sb_acc.push_back(e);
    endtask

    // Present one byte and hold it until the edge that accepts it; returns
    // on the following falling edge with in_valid dropped
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        while (!bif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL send_byte_stall: byte %h not accepted, in_ready=%b required 1", b, bif.in_ready);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_bytes.size() != 0 || sb_acc.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (bif.in_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_in_ready: got %b, required 1", bif.in_ready);
        end
        compared++;
        if (bif.out_valid !== 1'b0 || bif.out_data !== 8'h00) begin
            mismatched++; $display("FAIL reset_out: valid=%b data=%h, required 0 00", bif.out_valid, bif.out_data);
        end
        compared++;
        if (bif.bus_request !== 1'b0 || bif.enable !== 1'b0 || bif.write_en !== 1'b0) begin
            mismatched++; $display("FAIL reset_bus_ctrl: req=%b en=%b we=%b, required 000",
                                   bif.bus_request, bif.enable, bif.write_en);
        end
        compared++;
        if (bif.addr !== 16'h0000 || bif.data_out !== 16'h0000) begin
            mismatched++; $display("FAIL reset_bus_data: addr=%h data=%h, required 0000 0000", bif.addr, bif.data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        push_acc(16'hFF00, 1'b1, 16'h1234);
        sb_bytes.push_back(8'h06);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h34); send_byte(8'h12);
        #1;
        compared++;
        if (bif.bus_request !== 1'b1 || bif.enable !== 1'b0) begin
            mismatched++; $display("FAIL write_req_latency: req=%b en=%b, required 1 0", bif.bus_request, bif.enable);
        end
        @(negedge clk); #1;
        compared++;
        if (bif.enable !== 1'b1 || bif.write_en !== 1'b1) begin
            mismatched++; $display("FAIL write_access_latency: en=%b we=%b, required 1 1", bif.enable, bif.write_en);
        end
        @(negedge clk); #1;
        compared++;
        if (bif.out_valid !== 1'b1 || bif.enable !== 1'b0) begin
            mismatched++; $display("FAIL write_resp_latency: out_valid=%b en=%b, required 1 0", bif.out_valid, bif.enable);
        end
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL write_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
        #1;
        compared++;
        if (bif.addr !== 16'hFF00 || bif.data_out !== 16'h1234) begin
            mismatched++; $display("FAIL write_hold: addr=%h data=%h, required FF00 1234", bif.addr, bif.data_out);
        end
    endtask

    task automatic test_read_stall();
        int n;
        bif.data_in   = 16'h00A5;
        bif.out_ready = 1'b0;
        push_acc(16'hFF05, 1'b0, 16'h0000);
        sb_bytes.push_back(8'hA5);
        sb_bytes.push_back(8'h00);
        send_byte(8'h52); send_byte(8'h05); send_byte(8'hFF);
        #1;
        n = 0;
        while (!bif.out_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        compared++;
        if (bif.out_valid !== 1'b1 || bif.out_data !== 8'hA5) begin
            mismatched++; $display("FAIL read_first_byte: valid=%b data=%h, required 1 A5", bif.out_valid, bif.out_data);
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (bif.out_valid !== 1'b1 || bif.out_data !== 8'h00) begin
                mismatched++; $display("FAIL read_stall_hold: cycle %0d valid=%b data=%h, required 1 00",
                                       i, bif.out_valid, bif.out_data);
            end
            @(negedge clk);
        end
        bif.out_ready = 1'b1;
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL read_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
    endtask

    task automatic test_unknown();
        sb_bytes.push_back(8'h15);
        send_byte(8'h41);
        drain();
        bif.data_in = 16'hBEEF;
        push_acc(16'h0000, 1'b0, 16'h0000);
        sb_bytes.push_back(8'hEF);
        sb_bytes.push_back(8'hBE);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL unknown_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
    endtask

    task automatic test_timeout();
        int req_seen;
        req_seen = 0;
        send_byte(8'h52); send_byte(8'h05);
        for (int i = 0; i < TMO + 2; i++) begin
            #1;
            if (bif.bus_request) req_seen++;
            @(negedge clk);
        end
        compared++;
        if (req_seen != 0) begin
            mismatched++; $display("FAIL timeout_no_request: request cycles=%0d, required 0", req_seen);
        end
        bif.data_in = 16'h3C5A;
        push_acc(16'hFF05, 1'b0, 16'h0000);
        sb_bytes.push_back(8'h5A);
        sb_bytes.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h05); send_byte(8'hFF);
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL timeout_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
    endtask

    task automatic test_grant_stall();
        int bad;
        int en_cycles;
        bad = 0;
        en_cycles = 0;
        bif.bus_grant = 1'b0;
        push_acc(16'h1234, 1'b1, 16'hABCD);
        sb_bytes.push_back(8'h06);
        send_byte(8'h57); send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bif.bus_request !== 1'b1 || bif.enable !== 1'b0) bad++;
            @(negedge clk);
        end
        compared++;
        if (bad != 0) begin
            mismatched++; $display("FAIL grant_stall_hold: bad cycles=%0d, required 0", bad);
        end
        bif.bus_grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (bif.enable) en_cycles++;
        end
        compared++;
        if (en_cycles != 1) begin
            mismatched++; $display("FAIL grant_enable_count: enable cycles=%0d, required 1", en_cycles);
        end
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL grant_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
    endtask

    task automatic test_reset_mid_response();
        int n;
        n = 0;
        bif.data_in = 16'h00A5;
        push_acc(16'hFF05, 1'b0, 16'h0000);
        sb_bytes.push_back(8'hA5);
        send_byte(8'h52); send_byte(8'h05); send_byte(8'hFF);
        while (sb_bytes.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        #1;
        compared++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.bus_request !== 1'b0) begin
            mismatched++; $display("FAIL reset_mid_resp: out_valid=%b in_ready=%b req=%b, required 0 1 0",
                                   bif.out_valid, bif.in_ready, bif.bus_request);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_acc(16'h55AA, 1'b1, 16'hBEEF);
        sb_bytes.push_back(8'h06);
        send_byte(8'h57); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hEF); send_byte(8'hBE);
        drain();
        compared++;
        if (sb_bytes.size() + sb_acc.size() != 0) begin
            mismatched++; $display("FAIL reset_recover_drain: pending=%0d, required 0", sb_bytes.size() + sb_acc.size());
        end
    endtask

    initial begin
        reset         = 1'b0;
        bif.in_data   = 8'h00;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        bif.bus_grant = 1'b1;
        bif.data_in   = '0;
        test_reset();
        test_write();
        test_read_stall();
        test_unknown();
        test_timeout();
        test_grant_stall();
        test_reset_mid_response();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reflet_debug_bridge.md
# reflet_debug_bridge

Byte-stream-to-system-bus initiator. It turns commands arriving as bytes, normally from a UART receiver, into single read or write transactions on the Reflet system bus, and returns response bytes. It is the initiator counterpart of the peripheral block, which only responds on that bus. It requests the bus through a request/grant pair so the CPU keeps priority, and is used for host-side debug, peeking and poking of memory and peripheral registers.

## Interface
- `wordsize`, 16, bus data width; must be a multiple of 8.
- `base_addr_size`, 16, bus address width.
- `timeout_cycles`, 1000000, idle cycles that abort a partially received command; minimum 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- `in_data`  in  8  command byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  bridge accepts a byte on this edge.
- `out_data`  out  8  response byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the response byte.
- `bus_request`  out  1  bridge wants the system bus.
- `bus_grant`  in  1  arbiter grants the bus.
- `enable`  out  1  bus access strobe.
- `addr`  out  base_addr_size  bus address.
- `data_out`  out  wordsize  bus write data.
- `data_in`  in  wordsize  bus read data.
- `write_en`  out  1  bus write strobe.

## Operation
- Derived widths: AB = (base_addr_size+7)/8 address bytes; WB = wordsize/8 data bytes. All multi-byte fields are little-endian (LSB byte first). Address bits beyond base_addr_size in the last address byte are ignored.
- Command format:
  - Write: 0x57 ('W'), AB address bytes, WB data bytes. Response: one byte 0x06.
  - Read: 0x52 ('R'), AB address bytes. Response: WB bytes of read data.
  - Any other first byte: response is one byte 0x15, then return to IDLE.
- Byte handshake: a byte transfers on a rising edge where valid and ready are both 1.
- State machine:
  - IDLE: in_ready=1. A command byte moves to ADDR, or to NAK if the byte is unknown.
  - ADDR: in_ready=1. Shift in address bytes. After byte AB, a write moves to DATA and a read moves to REQ.
  - DATA: in_ready=1. Shift in data bytes. After byte WB, move to REQ.
  - REQ: bus_request=1. Move to ACCESS on the edge where bus_grant=1.
  - ACCESS: exactly one cycle. bus_request=1, enable=1, addr and data_out driven, write_en=1 for writes only. data_in is captured on the closing edge. Then move to RESP.
  - RESP / NAK: out_valid=1. Each accepted byte advances a byte counter. After the last byte, return to IDLE.
- Timeout: in ADDR or DATA, a counter increments every cycle with no accepted byte and clears on each accepted byte. When it reaches timeout_cycles-1, return to IDLE with no bus activity and no response. There is no timeout in REQ or RESP; the bridge waits indefinitely there.
- `addr` and `data_out` hold their values outside ACCESS. Bus consumers must qualify them with `enable`.
- One command is handled at a time. in_ready=0 from REQ through the last response byte.

## Timing
- Reset values: state IDLE, so in_ready=1 while reset is asserted. All other outputs are 0: out_valid, out_data, bus_request, enable, write_en, addr, data_out. Counters are cleared.
- Reset asserted in any state, including mid-command, REQ, ACCESS or mid-response, aborts immediately and asynchronously. A partial response is never resumed.
- Latency, last command byte to bus access: 1 cycle to enter REQ. ACCESS follows on the first edge with bus_grant=1 in REQ, so a grant held high gives ACCESS 2 cycles after the last byte.
- First response byte: out_valid rises the cycle after ACCESS. Each byte is held stable until out_ready=1.
- Dropping bus_grant while in REQ keeps the bridge in REQ. The grant is not re-checked during ACCESS, which completes its single cycle regardless.
- in_valid asserted while in_ready=0 is ignored; the byte is not consumed.

## Test plan
- Write command (wordsize=16, base_addr_size=16), grant tied high: bytes 57 00 FF 34 12 -> one ACCESS cycle with enable=1, write_en=1, addr=FF00, data_out=1234; then out_data=06.
- Read command: bytes 52 05 FF with data_in=00A5 during ACCESS -> addr=FF05, write_en=0; response bytes A5 then 00; stall out_ready low for 3 cycles between the bytes and check out_data is held.
- Unknown command: byte 41 -> response 15 only; enable never asserted; next command 52 00 00 executes normally.
- Timeout (timeout_cycles=8): send 52 05, then idle 8 cycles -> back in IDLE, no bus_request; then 52 05 FF -> read at FF05 succeeds.
- Grant stall: bus_grant low for 10 cycles after a write command -> bus_request high and enable low throughout; raising the grant gives exactly one enable cycle.
- Reset mid-response: assert reset during the read response after byte A5 -> out_valid=0 and in_ready=1 immediately; after release, a new command works.
